// File: rtl/nand_pkg.sv
// nand_pkg: shared types, default timing and helpers for the NAND command sequencer.
// Holds the FSM state encoding, the CLE/ALE byte-type encoding and the default
// WE# timing constants used as parameter defaults by nand_cmd_seq.
package nand_pkg;

  // Sequencer phases; IDLE must stay at zero so a cleared register is idle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WE_LO = 3'd2,
    ST_WE_HI = 3'd3,
    ST_WHR   = 3'd4
  } nand_state_e;

  // Byte type as it arrives on in_is_addr: command bytes raise CLE, address bytes ALE.
  typedef enum logic {
    BT_CMD  = 1'b0,
    BT_ADDR = 1'b1
  } nand_byte_e;

  // Default timing in v_clk0 cycles. T_SETUP of 3 covers the PHY's two-stage
  // clk90 resynchroniser on the command path.
  localparam int DEF_T_SETUP = 3;
  localparam int DEF_T_WP    = 3;
  localparam int DEF_T_WH    = 2;
  localparam int DEF_T_WHR   = 12;

  // Counter width able to hold the largest phase length.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Chip-select normalisation: anything other than a clean CE1 request targets CE0.
  function automatic logic [1:0] norm_ce(input logic [1:0] sel);
    return (sel == 2'b10) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nand_cmd_seq_if.sv
// nand_cmd_seq_if: byte request channel into the NAND command sequencer.
// Ports: in_valid/in_ready handshake; in_byte, in_is_addr (0 cmd, 1 addr),
// in_last (final byte of transaction), in_ce_sel (one-hot target chip).
interface nand_cmd_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_is_addr;
  logic [7:0] in_byte;
  logic       in_last;
  logic [1:0] in_ce_sel;

  // Requester side: offers bytes, watches ready.
  modport master (
    output in_valid,
    output in_is_addr,
    output in_byte,
    output in_last,
    output in_ce_sel,
    input  in_ready
  );

  // Sequencer side: consumes bytes, drives ready.
  modport slave (
    input  in_valid,
    input  in_is_addr,
    input  in_byte,
    input  in_last,
    input  in_ce_sel,
    output in_ready
  );
endinterface

// File: rtl/nand_phase_timer.sv
// nand_phase_timer: loadable down-counter timing one sequencer phase.
// Latency: load takes effect on the next edge; expire is combinational on the count.
// Ports: v_clk0/v_rst0, load + load_val (phase length minus one), expire (count == 0).
module nand_phase_timer #(
  parameter int W = 4
) (
  input  logic         v_clk0,
  input  logic         v_rst0,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Saturates at zero so an idle timer never wraps back to a large count.
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/nand_cmd_seq.sv
// nand_cmd_seq: drives one command/address byte at a time onto the NAND PHY with WE# timing.
// Latency: accept at edge N -> WE# low N+T_SETUP+1..N+T_SETUP+T_WP; ready again after T_WH
//          (non-last) or done after a further T_WHR cycles (last). Backpressure: in_ready only in IDLE.
// Ports: v_clk0/v_rst0 (sync, active-high); req (byte channel); busy/done status;
//        v_ctrl_* pin levels, v_dq_cmd_sel/v_dq_cmd_oe_n and v_wr_cmd towards the PHY.
module nand_cmd_seq
  import nand_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_WP    = DEF_T_WP,
  parameter int T_WH    = DEF_T_WH,
  parameter int T_WHR   = DEF_T_WHR
) (
  input  logic          v_clk0,
  input  logic          v_rst0,
  nand_cmd_seq_if.slave req,
  output logic          busy,
  output logic          done,
  output logic          v_ctrl_cle,
  output logic          v_ctrl_ale,
  output logic          v_ctrl_wrn,
  output logic          v_ctrl_wpn,
  output logic [1:0]    v_ctrl_cen,
  output logic          v_ctrl_wen,
  output logic          v_ctrl_wen_sel,
  output logic          v_dq_cmd_sel,
  output logic          v_dq_cmd_oe_n,
  output logic [7:0]    v_wr_cmd
);

  localparam int CW = cnt_width(T_SETUP, T_WP, T_WH, T_WHR);

  // Timer reload values: a phase of length L counts L-1 down to 0.
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_WP    = CW'(T_WP - 1);
  localparam logic [CW-1:0] LD_WH    = CW'(T_WH - 1);
  localparam logic [CW-1:0] LD_WHR   = (T_WHR > 0) ? CW'(T_WHR - 1) : '0;

  nand_state_e state, state_nxt;

  // Latched request fields.
  logic [7:0]  byte_q;
  nand_byte_e  type_q;
  logic        last_q;
  logic [1:0]  ce_q;
  logic        txn_q;   // inside a multi-byte transaction; CE# stays asserted

  logic          accept;
  logic          done_nxt;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_expire;

  // Next-cycle view of the latched fields, used to build registered outputs.
  logic [7:0]  byte_n;
  nand_byte_e  type_n;
  logic        last_n;
  logic [1:0]  ce_n;
  logic        txn_n;
  logic        drive_n;

  // Registered pin levels.
  logic        busy_q, done_q, cle_q, ale_q, wen_q, oe_n_q;
  logic [1:0]  cen_q;

  assign req.in_ready = (state == ST_IDLE);

  nand_phase_timer #(
    .W (CW)
  ) u_timer (
    .v_clk0   (v_clk0),
    .v_rst0   (v_rst0),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state and timer control.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (req.in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_val   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          state_nxt = ST_WE_LO;
          tmr_load  = 1'b1;
          tmr_val   = LD_WP;
        end
      end
      ST_WE_LO: begin
        if (tmr_expire) begin
          state_nxt = ST_WE_HI;
          tmr_load  = 1'b1;
          tmr_val   = LD_WH;
        end
      end
      ST_WE_HI: begin
        if (tmr_expire) begin
          if (!last_q) begin
            state_nxt = ST_IDLE;
          end else if (T_WHR == 0) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WHR;
            tmr_load  = 1'b1;
            tmr_val   = LD_WHR;
          end
        end
      end
      ST_WHR: begin
        if (tmr_expire) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Field capture and output levels derived from the next state, so every pin
  // is a flop and changes on the same edge the state does.
  always_comb begin
    byte_n  = accept ? req.in_byte : byte_q;
    type_n  = accept ? nand_byte_e'(req.in_is_addr) : type_q;
    last_n  = accept ? req.in_last : last_q;
    // Chip select is only taken from the first byte; chained bytes keep the target.
    ce_n    = (accept && !txn_q) ? norm_ce(req.in_ce_sel) : ce_q;
    txn_n   = accept ? 1'b1 : (done_nxt ? 1'b0 : txn_q);
    // DQ/CLE/ALE are driven from setup through the WE# hold window.
    drive_n = (state_nxt == ST_SETUP) || (state_nxt == ST_WE_LO) || (state_nxt == ST_WE_HI);
  end

  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state  <= ST_IDLE;
      byte_q <= '0;
      type_q <= BT_CMD;
      last_q <= 1'b0;
      ce_q   <= '0;
      txn_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cle_q  <= 1'b0;
      ale_q  <= 1'b0;
      wen_q  <= 1'b1;
      oe_n_q <= 1'b1;
      cen_q  <= 2'b11;
    end else begin
      state  <= state_nxt;
      byte_q <= byte_n;
      type_q <= type_n;
      last_q <= last_n;
      ce_q   <= ce_n;
      txn_q  <= txn_n;
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= done_nxt;
      cle_q  <= drive_n && (type_n == BT_CMD);
      ale_q  <= drive_n && (type_n == BT_ADDR);
      wen_q  <= (state_nxt != ST_WE_LO);
      oe_n_q <= !drive_n;
      cen_q  <= txn_n ? ~ce_n : 2'b11;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign v_ctrl_cle     = cle_q;
  assign v_ctrl_ale     = ale_q;
  assign v_ctrl_cen     = cen_q;
  assign v_ctrl_wen     = wen_q;
  assign v_dq_cmd_oe_n  = oe_n_q;
  // The byte register only loads on accept, so DQ is stable across WE# low.
  assign v_wr_cmd       = byte_q;

  // Write-only command path: RE#, WP# and the WE# mode select sit inactive.
  assign v_ctrl_wrn     = 1'b1;
  assign v_ctrl_wpn     = 1'b1;
  assign v_ctrl_wen_sel = 1'b1;
  assign v_dq_cmd_sel   = 1'b1;

endmodule

// File: tb/tb_nand_cmd_seq.sv
// tb_nand_cmd_seq: directed bench for nand_cmd_seq (default timing on dut_a,
// fast 4/1/1/0 timing on dut_b). Outputs are sampled 1 time unit after each edge.
module tb_nand_cmd_seq;

  logic v_clk0 = 1'b0;
  logic v_rst0 = 1'b1;
  always #5 v_clk0 = ~v_clk0;

  int cyc = 0;
  always @(posedge v_clk0) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  nand_cmd_seq_if ifa();
  nand_cmd_seq_if ifb();

  logic       a_busy, a_done, a_cle, a_ale, a_wrn, a_wpn, a_wen, a_wen_sel, a_cmd_sel, a_oe_n;
  logic [1:0] a_cen;
  logic [7:0] a_wr_cmd;
  logic       b_busy, b_done, b_cle, b_ale, b_wrn, b_wpn, b_wen, b_wen_sel, b_cmd_sel, b_oe_n;
  logic [1:0] b_cen;
  logic [7:0] b_wr_cmd;

  nand_cmd_seq dut_a (
    .v_clk0(v_clk0), .v_rst0(v_rst0), .req(ifa), .busy(a_busy), .done(a_done),
    .v_ctrl_cle(a_cle), .v_ctrl_ale(a_ale), .v_ctrl_wrn(a_wrn), .v_ctrl_wpn(a_wpn),
    .v_ctrl_cen(a_cen), .v_ctrl_wen(a_wen), .v_ctrl_wen_sel(a_wen_sel),
    .v_dq_cmd_sel(a_cmd_sel), .v_dq_cmd_oe_n(a_oe_n), .v_wr_cmd(a_wr_cmd)
  );

  nand_cmd_seq #(.T_SETUP(4), .T_WP(1), .T_WH(1), .T_WHR(0)) dut_b (
    .v_clk0(v_clk0), .v_rst0(v_rst0), .req(ifb), .busy(b_busy), .done(b_done),
    .v_ctrl_cle(b_cle), .v_ctrl_ale(b_ale), .v_ctrl_wrn(b_wrn), .v_ctrl_wpn(b_wpn),
    .v_ctrl_cen(b_cen), .v_ctrl_wen(b_wen), .v_ctrl_wen_sel(b_wen_sel),
    .v_dq_cmd_sel(b_cmd_sel), .v_dq_cmd_oe_n(b_oe_n), .v_wr_cmd(b_wr_cmd)
  );

  // Holds in_valid until the edge that accepts; returns 1 time unit after that edge.
  task automatic accept_a(output bit ok);
    bit hit;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      hit = ifa.in_ready;
      @(posedge v_clk0); #1;
      if (hit) ok = 1'b1;
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_idle_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (!a_busy) ok = 1'b1;
      else begin @(posedge v_clk0); #1; end
    end
  endtask

  task automatic test_reset();
    v_rst0 = 1'b1;
    ifa.in_valid = 0; ifa.in_is_addr = 0; ifa.in_byte = 8'h00; ifa.in_last = 0; ifa.in_ce_sel = 2'b01;
    ifb.in_valid = 0; ifb.in_is_addr = 0; ifb.in_byte = 8'h00; ifb.in_last = 0; ifb.in_ce_sel = 2'b01;
    @(posedge v_clk0); @(posedge v_clk0); #1;
    checks++; if ({a_busy, a_done, a_cle, a_ale} !== 4'b0000) begin errors++;
      $display("FAIL reset_status: got %b required 0000", {a_busy, a_done, a_cle, a_ale}); end
    checks++; if (a_cen !== 2'b11) begin errors++; $display("FAIL reset_cen: got %b required 11", a_cen); end
    checks++; if ({a_wen, a_oe_n} !== 2'b11) begin errors++;
      $display("FAIL reset_we_oe: got %b required 11", {a_wen, a_oe_n}); end
    checks++; if (a_wr_cmd !== 8'h00) begin errors++; $display("FAIL reset_wr_cmd: got %h required 00", a_wr_cmd); end
    checks++; if ({a_wrn, a_wpn, a_wen_sel, a_cmd_sel} !== 4'b1111) begin errors++;
      $display("FAIL reset_tieoffs: got %b required 1111", {a_wrn, a_wpn, a_wen_sel, a_cmd_sel}); end
    checks++; if ({b_cen, b_wen, b_oe_n} !== 4'b1111) begin errors++;
      $display("FAIL reset_b: got %b required 1111", {b_cen, b_wen, b_oe_n}); end
    v_rst0 = 1'b0;
    @(posedge v_clk0); #1;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ifa.in_ready); end
  endtask

  // Single 0xFF command, last byte, CE0: full timeline against default timing.
  task automatic test_single();
    bit ok;
    logic exp_cle, exp_wen, exp_done, exp_busy;
    logic [1:0] exp_cen;
    ifa.in_byte = 8'hFF; ifa.in_is_addr = 0; ifa.in_last = 1; ifa.in_ce_sel = 2'b01; ifa.in_valid = 1;
    accept_a(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept: got %b required 1", ok); end
    for (int k = 1; k <= 24; k++) begin
      exp_cle  = (k <= 8);
      exp_wen  = !(k >= 4 && k <= 6);
      exp_done = (k == 21);
      exp_busy = (k <= 20);
      exp_cen  = (k <= 20) ? 2'b10 : 2'b11;
      checks++; if (a_cle !== exp_cle) begin errors++; $display("FAIL single_cle k=%0d: got %b required %b", k, a_cle, exp_cle); end
      checks++; if (a_oe_n !== !exp_cle) begin errors++; $display("FAIL single_oe_n k=%0d: got %b required %b", k, a_oe_n, !exp_cle); end
      checks++; if (a_wen !== exp_wen) begin errors++; $display("FAIL single_wen k=%0d: got %b required %b", k, a_wen, exp_wen); end
      checks++; if (a_done !== exp_done) begin errors++; $display("FAIL single_done k=%0d: got %b required %b", k, a_done, exp_done); end
      checks++; if (a_busy !== exp_busy) begin errors++; $display("FAIL single_busy k=%0d: got %b required %b", k, a_busy, exp_busy); end
      checks++; if (a_cen !== exp_cen) begin errors++; $display("FAIL single_cen k=%0d: got %b required %b", k, a_cen, exp_cen); end
      if (k <= 8) begin
        checks++; if (a_wr_cmd !== 8'hFF) begin errors++; $display("FAIL single_wr_cmd k=%0d: got %h required ff", k, a_wr_cmd); end
      end
      @(posedge v_clk0); #1;
    end
  endtask

  // Page read command sequence on CE1 with in_valid held high.
  task automatic test_read_seq();
    logic [7:0] bytes [7] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h30};
    logic [6:0] addr_map = 7'b0111110;
    logic [6:0] ale_bits = '0;
    int idx = 0, pulses = 0, done_cnt = 0, cen_bad = 0, ale_cyc = 0, cle_cyc = 0;
    bit started = 0, done_seen = 0, acc;
    logic prev_wen = 1'b1;
    ifa.in_byte = bytes[0]; ifa.in_is_addr = addr_map[0]; ifa.in_last = 0; ifa.in_ce_sel = 2'b10; ifa.in_valid = 1;
    for (int i = 0; i < 120; i++) begin
      if (a_done) begin done_cnt++; done_seen = 1; end
      if (started && !done_seen && a_cen !== 2'b01) cen_bad++;
      if (prev_wen && !a_wen) begin
        if (pulses < 7) ale_bits[pulses] = a_ale;
        pulses++;
      end
      if (a_ale) ale_cyc++;
      if (a_cle) cle_cyc++;
      prev_wen = a_wen;
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge v_clk0); #1;
      if (acc) begin
        started = 1; idx++;
        if (idx < 7) begin
          ifa.in_byte = bytes[idx]; ifa.in_is_addr = addr_map[idx]; ifa.in_last = (idx == 6);
          ifa.in_ce_sel = 2'b01;
        end else ifa.in_valid = 0;
      end
    end
    checks++; if (idx !== 7) begin errors++; $display("FAIL read_accepts: got %0d required 7", idx); end
    checks++; if (pulses !== 7) begin errors++; $display("FAIL read_we_pulses: got %0d required 7", pulses); end
    checks++; if (ale_bits !== 7'b0111110) begin errors++; $display("FAIL read_ale_per_pulse: got %b required 0111110", ale_bits); end
    checks++; if (ale_cyc !== 40) begin errors++; $display("FAIL read_ale_cycles: got %0d required 40", ale_cyc); end
    checks++; if (cle_cyc !== 16) begin errors++; $display("FAIL read_cle_cycles: got %0d required 16", cle_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL read_done_count: got %0d required 1", done_cnt); end
    checks++; if (cen_bad !== 0) begin errors++; $display("FAIL read_cen_held: got %0d bad cycles required 0", cen_bad); end
    checks++; if (a_cen !== 2'b11) begin errors++; $display("FAIL read_cen_after: got %b required 11", a_cen); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [2];
    int n = 0;
    bit acc, ok;
    logic ready_after = 1'b1;
    ifa.in_byte = 8'h70; ifa.in_is_addr = 0; ifa.in_last = 0; ifa.in_ce_sel = 2'b01; ifa.in_valid = 1;
    for (int i = 0; i < 40 && n < 2; i++) begin
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge v_clk0); #1;
      if (acc) begin
        acc_cyc[n] = cyc; n++;
        if (n == 1) begin ready_after = ifa.in_ready; ifa.in_byte = 8'h71; ifa.in_last = 1; end
        else ifa.in_valid = 0;
      end
    end
    ifa.in_valid = 0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d required 2", n); end
    checks++; if (ready_after !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b required 0", ready_after); end
    if (n == 2) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 9) begin errors++;
        $display("FAIL b2b_spacing: got %0d required 9", acc_cyc[1] - acc_cyc[0]); end
    end
    wait_idle_a(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_idle_timeout: got %b required 1", ok); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dn = 0;
    ifa.in_byte = 8'h90; ifa.in_is_addr = 0; ifa.in_last = 1; ifa.in_ce_sel = 2'b01; ifa.in_valid = 1;
    accept_a(ok);
    for (int k = 1; k < 4; k++) begin @(posedge v_clk0); #1; end
    checks++; if (a_wen !== 1'b0) begin errors++; $display("FAIL rstmid_in_we_lo: got %b required 0", a_wen); end
    v_rst0 = 1'b1;
    @(posedge v_clk0); #1;
    checks++; if ({a_wen, a_cen, a_oe_n} !== 4'b1111) begin errors++;
      $display("FAIL rstmid_pins: got %b required 1111", {a_wen, a_cen, a_oe_n}); end
    if (a_done) dn++;
    v_rst0 = 1'b0;
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", ifa.in_ready); end
    for (int i = 0; i < 25; i++) begin
      @(posedge v_clk0); #1;
      if (a_done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d required 0", dn); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b required 0", a_busy); end
  endtask

  task automatic test_chained_ce();
    int idx = 0, bad = 0, dn = 0;
    bit started = 0, done_seen = 0, acc;
    ifa.in_ce_sel = 2'b01; ifa.in_is_addr = 0; ifa.in_byte = 8'h05; ifa.in_last = 0; ifa.in_valid = 1;
    for (int i = 0; i < 60; i++) begin
      if (a_done) begin dn++; done_seen = 1; end
      if (started && !done_seen && a_cen !== 2'b10) bad++;
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge v_clk0); #1;
      if (acc) begin
        started = 1; idx++;
        if (idx == 1) begin ifa.in_ce_sel = 2'b10; ifa.in_is_addr = 1; ifa.in_byte = 8'h3C; ifa.in_last = 1; end
        else ifa.in_valid = 0;
      end
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL chain_accepts: got %0d required 2", idx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL chain_cen_held: got %0d bad cycles required 0", bad); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL chain_done: got %0d required 1", dn); end
  endtask

  task automatic test_ce_norm();
    logic [1:0] sels [2] = '{2'b11, 2'b00};
    bit ok;
    for (int p = 0; p < 2; p++) begin
      ifa.in_byte = 8'hA5; ifa.in_is_addr = 0; ifa.in_last = 1; ifa.in_ce_sel = sels[p]; ifa.in_valid = 1;
      accept_a(ok);
      checks++; if (a_cen !== 2'b10) begin errors++;
        $display("FAIL ce_norm sel=%b: got %b required 10", sels[p], a_cen); end
      wait_idle_a(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ce_norm_idle_timeout: got %b required 1", ok); end
    end
  endtask

  task automatic test_fast_params();
    bit ok = 0, hit;
    ifb.in_byte = 8'hEF; ifb.in_is_addr = 0; ifb.in_last = 1; ifb.in_ce_sel = 2'b01; ifb.in_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      hit = ifb.in_ready;
      @(posedge v_clk0); #1;
      if (hit) ok = 1;
    end
    ifb.in_valid = 0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fast_accept: got %b required 1", ok); end
    for (int k = 1; k <= 10; k++) begin
      checks++; if (b_wen !== (k != 5)) begin errors++; $display("FAIL fast_wen k=%0d: got %b required %b", k, b_wen, (k != 5)); end
      checks++; if (b_done !== (k == 7)) begin errors++; $display("FAIL fast_done k=%0d: got %b required %b", k, b_done, (k == 7)); end
      checks++; if (b_cle !== (k <= 6)) begin errors++; $display("FAIL fast_cle k=%0d: got %b required %b", k, b_cle, (k <= 6)); end
      @(posedge v_clk0); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_read_seq();
    test_back_to_back();
    test_reset_mid();
    test_chained_ce();
    test_ce_norm();
    test_fast_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nand_cmd_seq.md
NAND_CMD_SEQ -- requirements
Module: nand_cmd_seq

Interface
REQ-001 SHALL have parameter T_SETUP, default 3: cycles CLE/ALE/DQ are valid before WE# falls. Legal minimum is 3, which covers the PHY's two-stage clk90 sync of the command path.
REQ-002 SHALL have parameter T_WP, default 3: WE# low cycles (minimum 1).
REQ-003 SHALL have parameter T_WH, default 2: WE# high cycles after each byte (minimum 1).
REQ-004 SHALL have parameter T_WHR, default 12: idle cycles after a last byte before done (minimum 0).
REQ-005 SHALL have ports (clock and reset first):
- v_clk0  in  1  sole clock.
- v_rst0  in  1  synchronous, active-high reset.
- in_valid  in  1  byte request valid.
- in_ready  out  1  sequencer can accept a byte.
- in_is_addr  in  1  0 = command byte (CLE), 1 = address byte (ALE).
- in_byte  in  8  byte to drive on DQ.
- in_last  in  1  final byte of the transaction.
- in_ce_sel  in  2  one-hot target; the selected CE# is driven low.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when a last byte completes.
- v_ctrl_cle, v_ctrl_ale  out  1 each  to the PHY.
- v_ctrl_wrn  out  1  RE#; held at 1.
- v_ctrl_wpn  out  1  held at 1.
- v_ctrl_cen  out  2  active-low chip enables.
- v_ctrl_wen  out  1  WE# level.
- v_ctrl_wen_sel  out  1  held at 1 (async WE# mode).
- v_dq_cmd_sel  out  1  selects the command path on DQ.
- v_dq_cmd_oe_n  out  1  DQ output enable, active-low.
- v_wr_cmd  out  8  command/address byte.

Function
REQ-006 SHALL implement states IDLE, SETUP, WE_LO, WE_HI, WHR, with state/counter registers and registered outputs.
REQ-007 in_ready SHALL be 1 only in IDLE. A byte is accepted on the edge where in_valid && in_ready.
REQ-008 Accept SHALL latch in_byte, in_is_addr, in_last and in_ce_sel, then go to SETUP.
REQ-009 SETUP SHALL last T_SETUP cycles:
- v_wr_cmd = latched byte; v_dq_cmd_oe_n = 0; v_dq_cmd_sel = 1.
- CLE = !is_addr; ALE = is_addr.
- Selected CE# = 0; v_ctrl_wen = 1.
REQ-010 WE_LO SHALL last T_WP cycles with v_ctrl_wen = 0 and all other SETUP outputs held.
REQ-011 WE_HI SHALL last T_WH cycles with v_ctrl_wen = 1 and DQ, CLE, ALE still held (hold time).
REQ-012 After WE_HI, a non-last byte SHALL return to IDLE with CE# still low, CLE = ALE = 0 and v_dq_cmd_oe_n = 1.
REQ-013 After WE_HI, a last byte SHALL enter WHR for T_WHR cycles (CE# low, CLE = ALE = 0, oe_n = 1). It then goes to IDLE, pulses done for 1 cycle and drives both CE# high. With T_WHR = 0 it goes straight to IDLE.
REQ-014 Timing, with accept at edge N:
- SETUP covers cycles N+1..N+T_SETUP.
- WE_LO covers cycles N+T_SETUP+1..N+T_SETUP+T_WP.
- in_ready re-asserts at N+T_SETUP+T_WP+T_WH+1 (non-last).
- done fires at N+T_SETUP+T_WP+T_WH+T_WHR+1 (last).
REQ-015 in_ce_sel SHALL be sampled only at the first byte of a transaction. A differing in_ce_sel on a chained byte SHALL be ignored.
REQ-016 in_ce_sel = 2'b00 or 2'b11 SHALL be treated as 2'b01.
REQ-017 Counters SHALL be sized to the largest parameter and count down to 0 without wrap. A zero-length phase is not legal except WHR.
REQ-018 v_wr_cmd SHALL change only when v_dq_cmd_oe_n = 1 or on accept. It SHALL never change while WE# is low.

Reset
REQ-019 When v_rst0 = 1, the next edge SHALL force:
- state IDLE, counters 0, latched fields 0.
- in_ready 1 (after release), busy 0, done 0.
- CLE = ALE = 0, v_ctrl_cen = 2'b11, v_ctrl_wen = 1.
- v_dq_cmd_oe_n = 1, v_wr_cmd = 0.
- v_ctrl_wrn = v_ctrl_wpn = v_ctrl_wen_sel = v_dq_cmd_sel = 1.
REQ-020 Reset mid-operation (any state) SHALL abort with no done pulse. WE# SHALL return high on the same edge.

Structure
REQ-021 The shared package nand_pkg SHALL hold:
- state encoding.
- default timing constants (T_SETUP/T_WP/T_WH/T_WHR).
- CLE/ALE byte-type encoding.
REQ-022 A single sub-module, nand_phase_timer (loadable down-counter with an expire flag), SHALL time every phase.

Verification
REQ-023 Single command 0xFF, last = 1, ce_sel = 01, defaults, accept at N:
- CLE = 1, v_wr_cmd = 0xFF, oe_n = 0 over N+1..N+8.
- WE# low exactly N+4..N+6.
- done at N+21.
- cen = 2'b11 after done.
REQ-024 Read sequence: cmd 0x00, 5 address bytes (0x00,0x00,0x10,0x00,0x00), cmd 0x30 last, ce_sel = 10:
- cen stays 2'b01 throughout the transaction.
- ALE is high only for the 5 address bytes.
- exactly 7 WE# pulses.
- one done.
REQ-025 Back-to-back with in_valid held high: the second accept occurs exactly 9 cycles after the first.
REQ-026 Reset asserted during WE_LO:
- next edge gives WE# = 1, cen = 11, oe_n = 1.
- no done pulse.
- in_ready = 1 after release.
REQ-027 Chained byte with a changed ce_sel (01 to 10): CE# remains 2'b10 (original target held).
REQ-028 Parameters T_SETUP=4, T_WP=1, T_WH=1, T_WHR=0, last byte: done at N+7 and WE# low only at N+5.
